// File: rtl/prbs_pkg.sv
// Shared PRBS31 constants for the BER tester transmit and check sides.
package prbs_pkg;
    localparam int              PRBS_LEN          = 31;
    localparam int              PRBS_TAP          = 28;
    localparam int              BYTE_W            = 8;
    localparam logic [30:0]     PRBS_SEED_DEFAULT = 31'h0000_0001;
endpackage

// File: rtl/prbs31_next.sv
// Next PRBS31 (x^31 + x^28 + 1) byte from the current state, MSB first in time.
// Purely combinational; shared with the checker so both ends use identical taps.
module prbs31_next
    import prbs_pkg::*;
(
    input  logic [PRBS_LEN-1:0] state_i,
    output logic [BYTE_W-1:0]   byte_o
);

    always_comb begin
        byte_o = '0;
        for (int j = 0; j < BYTE_W; j++) begin
            byte_o[BYTE_W-1-j] = state_i[PRBS_LEN-1-j] ^ state_i[PRBS_TAP-1-j];
        end
    end

endmodule

// File: rtl/prbs_tx_gen.sv
// PRBS31 byte source with periodic and single-shot bit-error injection.
// Latency: one byte registered on the edge that samples en; no backpressure, en is the only pacing.
module prbs_tx_gen
    import prbs_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED       = PRBS_SEED_DEFAULT,
    parameter int unsigned         ERR_PERIOD = 1024,
    parameter int unsigned         ERR_BIT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              reseed,
    input  logic              inj_en,
    input  logic              inj_single,
    output logic [BYTE_W-1:0] prbs,
    output logic              valid,
    output logic [15:0]       err_cnt
);

    localparam logic [15:0]       PER_LAST  = 16'(ERR_PERIOD - 1);
    localparam logic [BYTE_W-1:0] FLIP_MASK = BYTE_W'(1 << ERR_BIT);

    logic [PRBS_LEN-1:0] state_q, state_d, state_eff;
    logic [15:0]         per_cnt_q, per_cnt_d;
    logic                pend_q, pend_d;
    logic [BYTE_W-1:0]   prbs_q, prbs_d;
    logic                valid_q, valid_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [BYTE_W-1:0]   clean_byte;
    logic                state_zero;
    logic                per_hit;
    logic                inject;

    // An all-zero state would lock the LFSR; substitute SEED so the stream restarts.
    assign state_zero = (state_q == '0);
    assign state_eff  = state_zero ? SEED : state_q;

    prbs31_next u_next (
        .state_i (state_eff),
        .byte_o  (clean_byte)
    );

    assign per_hit = inj_en && (per_cnt_q == PER_LAST);
    assign inject  = per_hit || pend_q || inj_single;

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        pend_d    = pend_q | inj_single;
        prbs_d    = prbs_q;
        valid_d   = 1'b0;
        err_cnt_d = err_cnt_q;

        if (reseed) begin
            state_d   = SEED;
            per_cnt_d = '0;
            pend_d    = 1'b0;
        end else begin
            if (!inj_en) begin
                per_cnt_d = '0;
            end else if (en) begin
                per_cnt_d = per_hit ? 16'd0 : per_cnt_q + 16'd1;
            end

            if (en) begin
                state_d = state_zero ? SEED : {state_q[PRBS_LEN-BYTE_W-1:0], clean_byte};
                prbs_d  = clean_byte ^ (inject ? FLIP_MASK : '0);
                valid_d = 1'b1;
                pend_d  = 1'b0;
                if (inject && (err_cnt_q != 16'hFFFF)) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEED;
            per_cnt_q <= '0;
            pend_q    <= 1'b0;
            prbs_q    <= '0;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            pend_q    <= pend_d;
            prbs_q    <= prbs_d;
            valid_q   <= valid_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign prbs    = prbs_q;
    assign valid   = valid_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: doc/prbs_tx_gen.md
# prbs_tx_gen

Transmit-side PRBS31 pattern source for the BER tester, feeding a DUT or loopback whose far end is checked by the 8-bit PRBS checker. It emits one byte per enabled cycle of the x^31 + x^28 + 1 sequence, MSB first in time, and has a registered valid qualifier. Controlled bit-error injection, periodic or single-shot, lets the checker's error count and lock/relock behaviour be exercised end to end.

## Interface
- SEED, 31'h0000_0001, LFSR load value after reset or on `reseed`; must be nonzero.
- ERR_PERIOD, 1024, enabled bytes between periodic injections; legal range 2..65535.
- ERR_BIT, 0, bit index (0..7) of the output byte flipped on injection.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance the LFSR and emit one byte this cycle.
- reseed  in  1  synchronous reload of SEED; wins over `en`.
- inj_en  in  1  periodic injection enable (level).
- inj_single  in  1  one-cycle pulse that requests exactly one injected error.
- prbs  out  8  output byte, registered.
- valid  out  1  `prbs` holds a new byte this cycle.
- err_cnt  out  16  injected-error count, saturating at 16'hFFFF.

## Operation
- Stream rule: s(t) = s(t-31) ^ s(t-28). The 31-bit state holds s[30] (oldest) to s[0] (newest).
- Next byte b: b[7-j] = s[30-j] ^ s[27-j] for j = 0..7, so b[7] is first in time.
- State update on `en`: s <= {s[22:0], b}. The state always takes the clean byte; injection never corrupts it.
- Output on `en`: prbs <= b ^ (inject ? (8'h1 << ERR_BIT) : 0), and valid <= 1. When `en` is low: valid <= 0 and `prbs` holds its value.
- Zero-state guard: if the state is all-zero on an `en` cycle, reload SEED in place of the shift and emit b computed from SEED.
- Periodic injection:
  - 16-bit period counter advances only on `en` cycles while `inj_en` = 1.
  - On reaching ERR_PERIOD-1: inject on that byte and wrap to 0.
  - `inj_en` = 0 clears the counter to 0.
- Single-shot injection:
  - `inj_single` sets a sticky pending flag.
  - The flag is consumed by the next `en` byte, including an `en` in the same cycle as the pulse.
  - A pulse arriving while the flag is already pending is absorbed; one error total.
- Coincidence: a periodic and a single injection on the same byte give one flip and err_cnt +1. The pending flag is still cleared.
- `reseed`:
  - State <= SEED, period counter <= 0, pending flag cleared, valid <= 0.
  - `err_cnt` is not cleared.
  - `en` in the same cycle is ignored.

## Timing
- Reset values: prbs = 8'h00, valid = 0, err_cnt = 0, state = SEED, period counter = 0, pending flag = 0.
- Latency: `en` sampled at edge N gives `prbs`/`valid` valid after edge N, for one cycle per `en`.
- Back-to-back `en` gives one byte per clock with no bubbles.
- `err_cnt` updates on the same edge as the corrupted `prbs` byte.
- Reset asserted mid-stream: all outputs go to reset values immediately, without waiting for a clock edge. The first `en` after release emits byte 1 of the SEED sequence.

## Structure
- Shared package `prbs_pkg`: PRBS31 tap constants (31, 28), byte width 8, default SEED.
- One sub-module, `prbs31_next`: combinational, 31-bit state in, 8-bit next byte out, using the equations above.
  - This generator instantiates it.
  - The checker is to reuse it so both ends share identical tap logic.

## Test plan
- Reset, SEED = 1, `en` held high: prbs = 00, 00, 00, 12 on the first four bytes; valid is high from the first edge after `en`.
- Loopback into the checker, no injection, 10k bytes: checker locks and its error count stays 0; err_cnt = 0.
- inj_en = 1, ERR_PERIOD = 4, ERR_BIT = 0: bytes 4, 8, 12 differ from the reference model in bit 0 only; err_cnt = 3 after 12 bytes; later clean bytes match the model.
- `inj_single` pulsed twice while en = 0, then one `en`: exactly one byte corrupted; err_cnt = 1.
- `inj_single` coinciding with a periodic hit, and separately `err_cnt` preset near 16'hFFFF: one flip and +1 for the coincidence; the count saturates at FFFF.
- `reset` asserted mid-stream, then `reseed` with `en` high: outputs go to reset values asynchronously; `reseed` suppresses that cycle's byte (valid = 0); the next `en` restarts at 00.
